// File: rtl/hazard_dest_tracker_pkg.sv
//------------------------------------------------------------------------------
// hazard_dest_tracker_pkg: shared types and constants for the hazard tracker.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package hazard_dest_tracker_pkg;
   localparam int REG_BITS         = 3;
   localparam int NUM_REGS         = 1 << REG_BITS;
   localparam int NUM_TRACK_STAGES = 3;

   typedef struct packed {
      logic                valid;
      logic [REG_BITS-1:0] rd;
   } stage_entry_t;

   localparam stage_entry_t EMPTY_ENTRY = '{valid: 1'b0, rd: '0};

   function automatic logic [NUM_REGS-1:0] rd_onehot(input stage_entry_t e);
      rd_onehot = e.valid ? (NUM_REGS'(1) << e.rd) : '0;
   endfunction
endpackage

`default_nettype wire

// File: rtl/hazard_stage_entry.sv
//------------------------------------------------------------------------------
// hazard_stage_entry: one tracked {valid, rd} slot with source-match output.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hazard_stage_entry
   import hazard_dest_tracker_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                load_i,
   input  logic                clear_i,
   input  stage_entry_t        entry_i,
   input  logic [REG_BITS-1:0] rs_i,
   input  logic                rs_used_i,
   input  logic [REG_BITS-1:0] rt_i,
   input  logic                rt_used_i,
   output stage_entry_t        entry_o,
   output logic                match_o
);
   stage_entry_t entry_q;
   stage_entry_t entry_d;

   always_comb begin
      entry_d = entry_q;
      if (clear_i) begin
         entry_d = EMPTY_ENTRY;
      end else if (load_i) begin
         entry_d = entry_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         entry_q <= EMPTY_ENTRY;
      end else begin
         entry_q <= entry_d;
      end
   end

   // An invalid slot never matches, whatever stale rd it might hold.
   assign match_o = entry_q.valid &
                    ((rs_used_i & (entry_q.rd == rs_i)) |
                     (rt_used_i & (entry_q.rd == rt_i)));
   assign entry_o = entry_q;
endmodule

`default_nettype wire

// File: rtl/hazard_dest_tracker.sv
//------------------------------------------------------------------------------
// hazard_dest_tracker: tracks in-flight destinations, raises decode stall.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hazard_dest_tracker
   import hazard_dest_tracker_pkg::*;
#(
   parameter int CNT_BITS = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                advance_i,
   input  logic                flush_i,
   input  logic                id_valid_i,
   input  logic                id_writes_i,
   input  logic [REG_BITS-1:0] id_rd_i,
   input  logic [REG_BITS-1:0] id_rs_i,
   input  logic                id_rs_used_i,
   input  logic [REG_BITS-1:0] id_rt_i,
   input  logic                id_rt_used_i,
   output logic                stall_o,
   output logic [REG_BITS-1:0] rdIDEX_o,
   output logic [REG_BITS-1:0] rdEXMEM_o,
   output logic [REG_BITS-1:0] rdMEMWB_o,
   output logic                vIDEX_o,
   output logic                vEXMEM_o,
   output logic                vMEMWB_o,
   output logic [NUM_REGS-1:0] pending_o,
   output logic [CNT_BITS-1:0] stall_count_o
);
   localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

   stage_entry_t                w_entry [NUM_TRACK_STAGES];
   logic [NUM_TRACK_STAGES-1:0] w_match;
   stage_entry_t                w_idex_d;
   logic                        w_stall;
   logic [NUM_REGS-1:0]         w_pending;
   logic [CNT_BITS-1:0]         stall_count_q;
   logic [CNT_BITS-1:0]         stall_count_d;

   assign w_stall = id_valid_i & ~flush_i & (|w_match);

   // Stalled, flushed or non-writing decode slots enter ID/EX as bubbles.
   always_comb begin
      w_idex_d = EMPTY_ENTRY;
      if (id_valid_i & id_writes_i & ~w_stall & ~flush_i) begin
         w_idex_d = '{valid: 1'b1, rd: id_rd_i};
      end
   end

   for (genvar i = 0; i < NUM_TRACK_STAGES; i++) begin : g_stage
      stage_entry_t w_in;
      logic         w_clear;
      if (i == 0) begin : g_head
         assign w_in    = w_idex_d;
         assign w_clear = ~advance_i & flush_i;
      end else begin : g_tail
         assign w_in    = w_entry[i-1];
         assign w_clear = 1'b0;
      end

      hazard_stage_entry u_entry (
         .clk       (clk),
         .rst       (rst),
         .load_i    (advance_i),
         .clear_i   (w_clear),
         .entry_i   (w_in),
         .rs_i      (id_rs_i),
         .rs_used_i (id_rs_used_i),
         .rt_i      (id_rt_i),
         .rt_used_i (id_rt_used_i),
         .entry_o   (w_entry[i]),
         .match_o   (w_match[i])
      );
   end

   always_comb begin
      w_pending = '0;
      for (int s = 0; s < NUM_TRACK_STAGES; s++) begin
         w_pending = w_pending | rd_onehot(w_entry[s]);
      end
   end

   always_comb begin
      stall_count_d = stall_count_q;
      if (advance_i && w_stall && (stall_count_q != CNT_MAX)) begin
         stall_count_d = stall_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_count_q <= '0;
      end else begin
         stall_count_q <= stall_count_d;
      end
   end

   assign stall_o       = w_stall;
   assign pending_o     = w_pending;
   assign stall_count_o = stall_count_q;
   assign rdIDEX_o      = w_entry[0].rd;
   assign rdEXMEM_o     = w_entry[1].rd;
   assign rdMEMWB_o     = w_entry[2].rd;
   assign vIDEX_o       = w_entry[0].valid;
   assign vEXMEM_o      = w_entry[1].valid;
   assign vMEMWB_o      = w_entry[2].valid;
endmodule

`default_nettype wire

// File: tb/tb_hazard_dest_tracker.sv
//------------------------------------------------------------------------------
// tb_hazard_dest_tracker: directed bench; a second 4-bit-counter instance
// shares the stimulus to exercise counter saturation. Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_hazard_dest_tracker;
   logic       clk = 1'b0;
   logic       rst;
   logic       advance, flush, id_valid, id_writes, id_rs_used, id_rt_used;
   logic [2:0] id_rd, id_rs, id_rt;

   logic        stall_a, vi_a, ve_a, vm_a;
   logic [2:0]  ri_a, re_a, rm_a;
   logic [7:0]  pend_a;
   logic [15:0] cnt_a;

   logic        stall_b, vi_b, ve_b, vm_b;
   logic [2:0]  ri_b, re_b, rm_b;
   logic [7:0]  pend_b;
   logic [3:0]  cnt_b;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   hazard_dest_tracker #(.CNT_BITS(16)) u_dut (
      .clk(clk), .rst(rst), .advance_i(advance), .flush_i(flush),
      .id_valid_i(id_valid), .id_writes_i(id_writes), .id_rd_i(id_rd),
      .id_rs_i(id_rs), .id_rs_used_i(id_rs_used), .id_rt_i(id_rt),
      .id_rt_used_i(id_rt_used), .stall_o(stall_a), .rdIDEX_o(ri_a),
      .rdEXMEM_o(re_a), .rdMEMWB_o(rm_a), .vIDEX_o(vi_a), .vEXMEM_o(ve_a),
      .vMEMWB_o(vm_a), .pending_o(pend_a), .stall_count_o(cnt_a)
   );

   hazard_dest_tracker #(.CNT_BITS(4)) u_dut_sat (
      .clk(clk), .rst(rst), .advance_i(advance), .flush_i(flush),
      .id_valid_i(id_valid), .id_writes_i(id_writes), .id_rd_i(id_rd),
      .id_rs_i(id_rs), .id_rs_used_i(id_rs_used), .id_rt_i(id_rt),
      .id_rt_used_i(id_rt_used), .stall_o(stall_b), .rdIDEX_o(ri_b),
      .rdEXMEM_o(re_b), .rdMEMWB_o(rm_b), .vIDEX_o(vi_b), .vEXMEM_o(ve_b),
      .vMEMWB_o(vm_b), .pending_o(pend_b), .stall_count_o(cnt_b)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic w, input logic [2:0] rd,
                         input logic [2:0] rs, input logic rsu,
                         input logic [2:0] rt, input logic rtu);
      id_valid = v; id_writes = w; id_rd = rd;
      id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
      #1;
   endtask

   task automatic do_reset;
      flush = 1'b0; advance = 1'b1;
      set_id(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
      rst = 1'b1;
      #1;
      rst = 1'b0;
   endtask

   // Counts consecutive stalled advancing cycles, bounded by limit.
   task automatic count_stalls(input int limit, output int n);
      n = 0;
      for (int i = 0; i < limit; i++) begin
         if (stall_a !== 1'b1) break;
         n++;
         tick();
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; advance = 1'b1; flush = 1'b0;
      set_id(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
      n_tests++;
      if ({vi_a, ve_a, vm_a, stall_a, pend_a} !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_state: v/stall/pending=%b%b%b %b %h want 000 0 00", vi_a, ve_a, vm_a, stall_a, pend_a);
      end
      n_tests++;
      if (cnt_a !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_count: got %0d want 0", cnt_a);
      end
      tick();
      rst = 1'b0;
      tick();
      set_id(1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 3'd0, 1'b1);
      n_tests++;
      if (stall_a !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_rd0_nomatch: stall=%b want 0", stall_a);
      end
   endtask

   task automatic test_reset_mid;
      do_reset();
      set_id(1'b1, 1'b1, 3'd1, 3'd0, 1'b0, 3'd0, 1'b0); tick();
      set_id(1'b1, 1'b1, 3'd2, 3'd0, 1'b0, 3'd0, 1'b0); tick();
      set_id(1'b1, 1'b1, 3'd3, 3'd0, 1'b0, 3'd0, 1'b0); tick();
      set_id(1'b1, 1'b0, 3'd0, 3'd1, 1'b1, 3'd0, 1'b0);
      n_tests++;
      if ({stall_a, pend_a, ri_a, re_a, rm_a} !== {1'b1, 8'h0E, 3'd3, 3'd2, 3'd1}) begin
         n_fail++;
         $display("FAIL mid_loaded: stall=%b pending=%h rd=%0d/%0d/%0d want 1 0e 3/2/1", stall_a, pend_a, ri_a, re_a, rm_a);
      end
      rst = 1'b1;
      #1;
      n_tests++;
      if ({vi_a, ve_a, vm_a, stall_a, pend_a, cnt_a} !== 28'h0) begin
         n_fail++;
         $display("FAIL mid_reset: v=%b%b%b stall=%b pending=%h cnt=%0d want all 0", vi_a, ve_a, vm_a, stall_a, pend_a, cnt_a);
      end
      rst = 1'b0;
   endtask

   task automatic test_back_to_back;
      int n;
      do_reset();
      set_id(1'b1, 1'b1, 3'd3, 3'd0, 1'b0, 3'd0, 1'b0); tick();
      set_id(1'b1, 1'b1, 3'd7, 3'd3, 1'b1, 3'd0, 1'b0);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         if (stall_a !== 1'b1) break;
         n++;
         n_tests++;
         if (pend_a !== 8'h08) begin
            n_fail++;
            $display("FAIL b2b_pending c%0d: got %h want 08", n, pend_a);
         end
         tick();
      end
      n_tests++;
      if (n != 3) begin
         n_fail++;
         $display("FAIL b2b_stalls: got %0d want 3", n);
      end
      n_tests++;
      if (cnt_a !== 16'd3) begin
         n_fail++;
         $display("FAIL b2b_count: got %0d want 3", cnt_a);
      end
      tick();
      n_tests++;
      if ({vi_a, ri_a} !== {1'b1, 3'd7}) begin
         n_fail++;
         $display("FAIL b2b_accept: vIDEX=%b rd=%0d want 1 7", vi_a, ri_a);
      end
   endtask

   task automatic test_gap_unused;
      int n;
      do_reset();
      set_id(1'b1, 1'b1, 3'd5, 3'd0, 1'b0, 3'd0, 1'b0); tick();
      set_id(1'b1, 1'b1, 3'd1, 3'd2, 1'b1, 3'd4, 1'b1); tick();
      set_id(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd5, 1'b1);
      count_stalls(10, n);
      n_tests++;
      if (n != 2) begin
         n_fail++;
         $display("FAIL gap1_stalls: got %0d want 2", n);
      end
      do_reset();
      set_id(1'b1, 1'b1, 3'd5, 3'd0, 1'b0, 3'd0, 1'b0); tick();
      set_id(1'b1, 1'b0, 3'd0, 3'd5, 1'b0, 3'd0, 1'b0);
      n_tests++;
      if (stall_a !== 1'b0) begin
         n_fail++;
         $display("FAIL unused_src: stall=%b want 0", stall_a);
      end
      set_id(1'b1, 1'b1, 3'd2, 3'd2, 1'b1, 3'd2, 1'b1);
      n_tests++;
      if (stall_a !== 1'b0) begin
         n_fail++;
         $display("FAIL own_rd: stall=%b want 0", stall_a);
      end
   endtask

   task automatic test_freeze;
      int n;
      do_reset();
      set_id(1'b1, 1'b1, 3'd2, 3'd0, 1'b0, 3'd0, 1'b0); tick();
      set_id(1'b1, 1'b0, 3'd0, 3'd2, 1'b1, 3'd0, 1'b0); tick();
      advance = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_tests++;
         if ({stall_a, vi_a, ve_a, re_a, vm_a, cnt_a} !== {1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 16'd1}) begin
            n_fail++;
            $display("FAIL freeze c%0d: stall=%b v=%b%b%b rdEXMEM=%0d cnt=%0d want 1 010 2 1", i, stall_a, vi_a, ve_a, vm_a, re_a, cnt_a);
         end
      end
      advance = 1'b1;
      #1;
      count_stalls(10, n);
      n_tests++;
      if ({n[3:0], cnt_a} !== {4'd2, 16'd3}) begin
         n_fail++;
         $display("FAIL freeze_resume: stalls=%0d cnt=%0d want 2 3", n, cnt_a);
      end
   endtask

   task automatic test_flush;
      do_reset();
      set_id(1'b1, 1'b1, 3'd4, 3'd0, 1'b0, 3'd0, 1'b0); tick();
      set_id(1'b1, 1'b1, 3'd6, 3'd4, 1'b1, 3'd0, 1'b0);
      flush = 1'b1;
      #1;
      n_tests++;
      if (stall_a !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_stall: stall=%b want 0", stall_a);
      end
      tick();
      flush = 1'b0;
      n_tests++;
      if ({vi_a, ve_a, re_a, pend_a, cnt_a} !== {1'b0, 1'b1, 3'd4, 8'h10, 16'd0}) begin
         n_fail++;
         $display("FAIL flush_edge: v=%b%b rdEXMEM=%0d pending=%h cnt=%0d want 01 4 10 0", vi_a, ve_a, re_a, pend_a, cnt_a);
      end
      set_id(1'b1, 1'b0, 3'd0, 3'd6, 1'b1, 3'd0, 1'b0);
      n_tests++;
      if (stall_a !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_killed_rd: stall=%b want 0", stall_a);
      end
      do_reset();
      set_id(1'b1, 1'b1, 3'd1, 3'd0, 1'b0, 3'd0, 1'b0); tick();
      set_id(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
      advance = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0; advance = 1'b1;
      n_tests++;
      if ({vi_a, ve_a, vm_a} !== 3'b000) begin
         n_fail++;
         $display("FAIL flush_frozen: v=%b%b%b want 000", vi_a, ve_a, vm_a);
      end
   endtask

   task automatic test_saturation;
      int n;
      do_reset();
      for (int r = 0; r < 8; r++) begin
         set_id(1'b1, 1'b1, 3'd3, 3'd0, 1'b0, 3'd0, 1'b0); tick();
         set_id(1'b1, 1'b0, 3'd0, 3'd3, 1'b1, 3'd3, 1'b1);
         count_stalls(10, n);
         tick();
         if (r == 6) begin
            n_tests++;
            if ({cnt_b, cnt_a} !== {4'd15, 16'd21}) begin
               n_fail++;
               $display("FAIL sat_reach: cnt4=%0d cnt16=%0d want 15 21", cnt_b, cnt_a);
            end
         end
      end
      n_tests++;
      if ({cnt_b, cnt_a} !== {4'd15, 16'd24}) begin
         n_fail++;
         $display("FAIL sat_hold: cnt4=%0d cnt16=%0d want 15 24", cnt_b, cnt_a);
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid();
      test_back_to_back();
      test_gap_unused();
      test_freeze();
      test_flush();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/hazard_dest_tracker.md
Name: hazard_dest_tracker

Overview:
- Producer side of the pipeline's hazard detection: records the destination register of each in-flight instruction as it moves through ID/EX, EX/MEM and MEM/WB, with a valid bit per stage.
- Compares the decode-stage sources against those entries and raises stall.
- Inserts bubbles into ID/EX while stalled and clears entries on flush.
- Sits beside the decode stage and the pipeline registers; there is no forwarding, and the register file does not bypass write-to-read.

Parameters:
- REG_BITS, 3, register specifier width (8 architectural registers, all writable).
- CNT_BITS, 16, width of the stall performance counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- advance  in  1  pipeline registers update this cycle (0 = global freeze, e.g. memory wait).
- flush  in  1  kill the instruction currently in decode (branch/jump taken in EX).
- id_valid  in  1  decode holds a real instruction.
- id_writes  in  1  decode instruction writes a register.
- id_rd  in  REG_BITS  decode destination.
- id_rs  in  REG_BITS  decode source 1.
- id_rs_used  in  1  source 1 is read.
- id_rt  in  REG_BITS  decode source 2.
- id_rt_used  in  1  source 2 is read.
- stall  out  1  hold fetch/decode and bubble ID/EX.
- rdIDEX, rdEXMEM, rdMEMWB  out  REG_BITS each  tracked destinations.
- vIDEX, vEXMEM, vMEMWB  out  1 each  entry valid.
- pending  out  2^REG_BITS  bit r set iff any valid entry targets r.
- stall_count  out  CNT_BITS  saturating count of stalled cycles.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - all valid bits 0, all rd fields 0, stall_count 0.
  - Outputs after reset: stall 0, pending 0.
- Combinational outputs:
  - match_s = id_rs_used & any stage with valid=1 and rd==id_rs; match_t is the same for id_rt.
  - stall = id_valid & ~flush & (match_s | match_t). Entries with valid=0 never match, whatever their rd value.
  - pending = OR over the three stages of (valid ? onehot(rd) : 0).
- Sequential update on the rising clk edge when advance=1:
  - MEMWB <= EXMEM and EXMEM <= IDEX (valid and rd move together).
  - IDEX <= {1, id_rd} iff id_valid & id_writes & ~stall & ~flush.
  - Otherwise IDEX <= {0, rd held at 0}. This bubble is inserted when stalled, flushed, or when the instruction does not write a register.
  - The MEMWB entry retires after one cycle: its write completes at the end of WB.
- advance=0:
  - all three entries hold their values.
  - flush=1 still clears vIDEX on that edge.
  - stall keeps being evaluated combinationally.
- Latency:
  - A writer decoded at edge N is visible in IDEX after edge N, in EXMEM after N+1, and in MEMWB after N+2.
  - A dependent instruction stalls for 3 advancing cycles and proceeds on the 4th.
  - With a 1-instruction gap, the dependent instruction stalls 2 cycles; with a 2-instruction gap, 1 cycle; with a 3-instruction gap, none.
- Simultaneous stall and flush: flush wins. stall is forced to 0 and the decode instruction is discarded, not bubbled twice.
- rs==rt with both used counts as one hazard. A source matching its own id_rd does not stall, because id_rd is not yet tracked.
- stall_count:
  - increments on an edge with advance=1 & stall=1.
  - saturates at 2^CNT_BITS-1 with no wrap.
  - it holds when advance=0.
- Reset asserted mid-stall: all entries are invalidated at once and stall drops in the same cycle (combinational from the cleared state).

Decomposition:
- Shared package holds:
  - REG_BITS;
  - the stage entry typedef {valid, rd};
  - constant NUM_TRACK_STAGES=3.
- One sub-module, hazard_stage_entry: one {valid, rd} register with async reset, load/hold/clear controls and a match output against two source specifiers. It is instantiated three times.
- The top level holds the shift control, the stall OR-tree, the pending decoder and the counter.

Test Plan:
- Reset mid-operation: load three writers r1, r2, r3, assert rst between edges -> vIDEX, vEXMEM and vMEMWB are 0 immediately; pending=0, stall=0 and stall_count=0 without waiting for a clock.
- Back-to-back RAW:
  - Stimulus: writer rd=3, then a reader with id_rs=3 and id_rs_used=1, advance held at 1.
  - Response: stall=1 for exactly 3 cycles; stall_count=3; reader is accepted on the 4th cycle.
  - Timing: pending[3]=1 for cycles 1-3.
- Gap and unused sources:
  - Writer rd=5, one independent instruction, then a reader with rt=5 -> 2 stall cycles.
  - Reader with rs=5 but id_rs_used=0 -> 0 stalls.
- Freeze: mid-stall, drop advance for 4 cycles -> entries are unchanged, stall stays 1, stall_count does not increment; hazard resolves 3 advancing cycles after the writer.
- Flush priority: stall and flush asserted in the same cycle -> stall=0; vIDEX=0 after the edge; a subsequent reader with rs equal to the killed rd does not stall on it.
- Saturation: force stall_count near max (CNT_BITS=4 build), hold a stall for 20 cycles -> stall_count=15 and holds.
